// File: rtl/multicycle_ctrl.sv
// Moore controller for a multicycle RV32I datapath (lw, sw, R, I-ALU, branch, jal).
// State and counters are registered; control outputs decode from the current state.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    state_t state_reg, state_next;
    logic   retire;
    logic   pc_update, branch, ir_write, mem_write, reg_write;

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            FETCH:    if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BR:        state_next = BRANCH;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_next = MEMWB;
            MEMWB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            MEMWRITE: if (mem_ready) begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            ALUWB: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            BRANCH: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            JAL:      state_next = ALUWB;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == TRAP) illegal <= 1'b1;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state_reg)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = mem_ready;
                pc_update = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset_n so a falling reset kills writes in the same cycle.
    assign PCWrite  = reset_n & (pc_update | (branch & zero));
    assign IRWrite  = reset_n & ir_write;
    assign MemWrite = reset_n & mem_write;
    assign RegWrite = reset_n & reg_write;

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BR:       ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle control words from the opcode rules, with random stalls and flags.
module tb_multicycle_ctrl;
    localparam int CW = 4;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
    localparam int K_RST = 0, K_FETCH = 1, K_DECODE = 2, K_MEMADR = 3, K_MEMREAD = 4;
    localparam int K_MEMWB = 5, K_MEMWRITE = 6, K_EXECR = 7, K_EXECI = 8;
    localparam int K_ALUWB = 9, K_BRANCH = 10, K_JAL = 11, K_TRAP = 12;

    logic clk = 1'b0, reset_n = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] op = 7'd0;
    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [CW-1:0] retired;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    int vectors = 0, misses = 0, ret_count = 0, cur_step = 0;
    logic chk_en = 1'b0;
    logic [15:0] exp_ctl = '0;
    logic [CW-1:0] exp_ret = '0;
    logic [6:0] cur_op = RT;

    function automatic logic [15:0] ctl(input int k, input logic mr, input logic z,
                                        input logic [6:0] o);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] res = 0, sa = 0, sb = 0, aop = 0, imm = 0;
        if (o == SW) imm = 2'b01;
        else if (o == BR) imm = 2'b10;
        else if (o == JL) imm = 2'b11;
        case (k)
            K_RST:      begin sb = 2; res = 2; end
            K_FETCH:    begin sb = 2; res = 2; irw = mr; pcw = mr; end
            K_DECODE:   begin sa = 1; sb = 1; end
            K_MEMADR:   begin sa = 2; sb = 1; end
            K_MEMREAD:  adr = 1;
            K_MEMWB:    begin res = 1; rw = 1; end
            K_MEMWRITE: begin adr = 1; mw = 1; end
            K_EXECR:    begin sa = 2; aop = 2; end
            K_EXECI:    begin sa = 2; sb = 1; aop = 2; end
            K_ALUWB:    rw = 1;
            K_BRANCH:   begin sa = 2; aop = 1; pcw = z; end
            K_JAL:      begin sa = 1; sb = 2; pcw = 1; end
            K_TRAP:     ill = 1;
            default: ;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, aop, imm, rw, ill};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
                 ImmSrc, RegWrite, illegal} !== exp_ctl) begin
                misses++;
                $display("FAIL ctl step=%0d op=%b got=%h exp=%h", cur_step, op,
                    {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                     ALUOp, ImmSrc, RegWrite, illegal}, exp_ctl);
            end
            vectors++;
            if (retired !== exp_ret) begin
                misses++;
                $display("FAIL retired step=%0d got=%0d exp=%0d", cur_step, retired, exp_ret);
            end
        end
    end

    task automatic pin(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            misses++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // Drive one cycle of step k, set the expected word, then advance to the next cycle.
    task automatic cyc(input int k, input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        op        = cur_op;
        cur_step  = k;
        exp_ctl   = ctl(k, mr, z, cur_op);
        exp_ret   = CW'(ret_count % (1 << CW));
        chk_en    = 1'b1;
        #2;
        if (k == K_BRANCH) pin("br_pcwrite", {3'b0, PCWrite}, {3'b0, z});
        if (k == K_JAL)    pin("jal_imm_pcw", {1'b0, ImmSrc, PCWrite}, 4'b0111);
        if (k == K_MEMWB)  pin("memwb_res_rw", {1'b0, ResultSrc, RegWrite}, 4'b0011);
        if (k == K_MEMWRITE) pin("memwrite", {3'b0, MemWrite}, 4'b0001);
        if (k == K_TRAP)   pin("trap_en_ill", {PCWrite | MemWrite, IRWrite, RegWrite, illegal},
                               4'b0001);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ret_count = 0;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            zero      = 1'($urandom);
            op        = cur_op;
            cur_step  = K_RST;
            exp_ctl   = ctl(K_RST, 1'b1, zero, cur_op);
            exp_ret   = '0;
            chk_en    = 1'b1;
            #2;
            pin("rst_en_ill", {PCWrite | MemWrite, IRWrite, RegWrite, illegal}, 4'b0000);
            @(posedge clk);
            #1;
        end
        reset_n = 1'b1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [6:0] o, input int fs, input int ms,
                             input int zsel, input int trap_cyc);
        cur_op = o;
        for (int i = 0; i < fs; i++) cyc(K_FETCH, 1'b0, rb());
        cyc(K_FETCH, 1'b1, rb());
        cyc(K_DECODE, rb(), rb());
        case (o)
            LW: begin
                cyc(K_MEMADR, rb(), rb());
                for (int i = 0; i < ms; i++) cyc(K_MEMREAD, 1'b0, rb());
                cyc(K_MEMREAD, 1'b1, rb());
                cyc(K_MEMWB, rb(), rb());
                ret_count++;
            end
            SW: begin
                cyc(K_MEMADR, rb(), rb());
                for (int i = 0; i < ms; i++) cyc(K_MEMWRITE, 1'b0, rb());
                cyc(K_MEMWRITE, 1'b1, rb());
                ret_count++;
            end
            RT, IT: begin
                cyc((o == RT) ? K_EXECR : K_EXECI, rb(), rb());
                cyc(K_ALUWB, rb(), rb());
                ret_count++;
            end
            BR: begin
                cyc(K_BRANCH, rb(), (zsel == 2) ? rb() : zsel[0]);
                ret_count++;
            end
            JL: begin
                cyc(K_JAL, rb(), rb());
                cyc(K_ALUWB, rb(), rb());
                ret_count++;
            end
            default: begin
                for (int i = 0; i < trap_cyc; i++) cyc(K_TRAP, rb(), rb());
                do_reset();
            end
        endcase
    endtask

    logic [6:0] legal_ops [6] = '{LW, SW, RT, IT, BR, JL};

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        run_instr(RT, 0, 0, 2, 0);
        pin("rtype_retired", 4'(retired), 4'd1);
        run_instr(LW, 0, 3, 2, 0);
        pin("lw_retired", 4'(retired), 4'd2);
        run_instr(SW, 2, 1, 2, 0);
        pin("sw_retired", 4'(retired), 4'd3);
        run_instr(BR, 0, 0, 1, 0);
        run_instr(BR, 0, 0, 0, 0);
        pin("br_retired", 4'(retired), 4'd5);
        run_instr(JL, 0, 0, 2, 0);
        pin("jal_retired", 4'(retired), 4'd6);
        run_instr(7'b1111111, 0, 0, 2, 20);
        pin("trap_cleared", {illegal, 3'(retired)}, 4'd0);
        // Reset landing mid-MEMWRITE and mid-ALUWB must kill the pending writes.
        cur_op = SW;
        cyc(K_FETCH, 1'b1, 1'b0);
        cyc(K_DECODE, 1'b0, 1'b0);
        cyc(K_MEMADR, 1'b0, 1'b0);
        cyc(K_MEMWRITE, 1'b0, 1'b0);
        do_reset();
        cur_op = IT;
        cyc(K_FETCH, 1'b1, 1'b0);
        cyc(K_DECODE, 1'b1, 1'b0);
        cyc(K_EXECI, 1'b1, 1'b0);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            o = legal_ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 99) < 4) begin
                do o = 7'($urandom);
                while (o inside {LW, SW, RT, IT, BR, JL});
            end
            run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                      $urandom_range(1, 20));
        end
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM controller that sequences a shared-ALU, shared-memory multicycle RV32I datapath: fetch, decode, execute, memory access and writeback.
- Supported subset: lw, sw, R-type, I-type ALU, beq/branch, jal.
- Emits per-state mux selects and write enables, PCWrite, and ImmSrc decode.
- Stalls on a memory-ready handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  opcode field of the instruction register.
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory accepted/completed current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select; 0=PC, 1=ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register and OldPC enable.
- ResultSrc  out  2  result mux; 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  SrcA select; 00=PC, 01=OldPC, 10=rs1 data.
- ALUSrcB  out  2  SrcB select; 00=rs2 data, 01=ImmExt, 10=constant 4.
- ALUOp  out  2  to ALU decoder; 00=add, 01=subtract/compare, 10=funct-decoded.
- ImmSrc  out  2  combinational from op; lw/I-type=00, sw=01, branch=10, jal=11, other=00.
- RegWrite  out  1  register file write enable.
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  retired instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Reset (reset_n low, asynchronous): state=FETCH, illegal=0, retired=0. IRWrite, PCWrite, MemWrite and RegWrite are forced 0 while reset_n is low. Other outputs take their FETCH values.
- Unlisted outputs are 0 in every state.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=mem_ready; PCUpdate=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - Next state: lw/sw -> MEMADR; R-type -> EXECR; I-type -> EXECI; branch -> BRANCH; jal -> JAL; any other op -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD on lw, MEMWRITE on sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state. Holds until mem_ready=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB (writes PC+4 to rd).
- PCWrite = PCUpdate | (Branch & zero), combinational, same cycle.
- TRAP: terminal until reset. All enables 0; illegal=1 from the first TRAP cycle until reset.
- retired increments by 1 on the final cycle of an instruction, i.e. the clock edge leaving MEMWB, MEMWRITE (with mem_ready=1), ALUWB or BRANCH.
  - JAL is counted once, at its ALUWB.
  - Wraps modulo 2^CNT_W.
  - A trapped instruction is not counted.
- op is sampled only in DECODE and MEMADR; the IR is stable then by construction.
- Reset mid-instruction: immediate return to FETCH. Any pending MemWrite/RegWrite is dropped in the same cycle reset_n falls.

Test Plan:
- Reset, then op=0110011 with mem_ready tied 1 -> state path FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 only in ALUWB. retired=1 after 4 cycles.
- op=0000011 with mem_ready=0 for 3 cycles in MEMREAD -> 5 + 3 = 8 cycles total. MEMWB asserts ResultSrc=01 and RegWrite. retired=1.
- op=0100011 with mem_ready held 0 for 2 cycles in FETCH -> IRWrite=0 and PCWrite=0 during the stall. MemWrite=1 throughout MEMWRITE. retired increments on exit.
- op=1100011: zero=1 -> PCWrite=1 in BRANCH; zero=0 -> PCWrite=0. Both cases take 3 cycles. ImmSrc=10.
- op=1101111 -> PCWrite=1 in JAL, ImmSrc=11, RegWrite in the following ALUWB. retired counts +1 only.
- op=1111111 -> TRAP after DECODE, illegal=1, all enables stay 0 for 20 cycles. Asserting reset_n low mid-TRAP clears illegal asynchronously and returns to FETCH.
